// File: rtl/reset_sequencer.sv
// Reset sequencer: filters PLL lock, holds, then releases STAGES reset domains STAGE_GAP cycles apart.
// All outputs are registered; lock loss or software request re-asserts every domain on the next edge.
module reset_sequencer #(
   parameter int LOCK_FILTER = 4,
   parameter int HOLD_CYCLES = 128,
   parameter int STAGES      = 2,
   parameter int STAGE_GAP   = 16
) (
   input  logic              c,
   input  logic              r,
   input  logic              locked,
   input  logic              sw_rst_req,
   output logic [STAGES-1:0] rst_out,
   output logic              all_released,
   output logic [1:0]        state,
   output logic [7:0]        lock_loss_cnt
);

   localparam int FW = $clog2(LOCK_FILTER) + 1;
   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam int GW = $clog2(STAGE_GAP) + 1;

   localparam logic [FW-1:0] FILT_TERM = FW'(LOCK_FILTER - 1);
   localparam logic [HW-1:0] HOLD_TERM = HW'(HOLD_CYCLES - 1);
   localparam logic [GW-1:0] GAP_TERM  = GW'(STAGE_GAP - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_e;

   state_e            state_q = WAIT_LOCK;
   state_e            state_d;
   logic [FW-1:0]     filt_q = '0;
   logic [FW-1:0]     filt_d;
   logic [HW-1:0]     hold_q = '0;
   logic [HW-1:0]     hold_d;
   logic [GW-1:0]     gap_q = '0;
   logic [GW-1:0]     gap_d;
   logic [STAGES-1:0] rst_out_q = '1;
   logic [STAGES-1:0] rst_out_d;
   logic              all_rel_q = 1'b0;
   logic              all_rel_d;
   logic [7:0]        llc_q = 8'd0;
   logic [7:0]        llc_d;

   logic              lock_loss;
   logic              sw_hit;
   logic [STAGES-1:0] rst_shift;

   // Domains release low-bit first, so each release is a left shift of the asserted mask.
   assign rst_shift = rst_out_q << 1;
   assign lock_loss = !locked && (state_q != WAIT_LOCK);
   assign sw_hit    = sw_rst_req && (state_q != WAIT_LOCK);

   always_ff @(posedge c) begin
      if (r) begin
         state_q   <= WAIT_LOCK;
         filt_q    <= '0;
         hold_q    <= '0;
         gap_q     <= '0;
         rst_out_q <= '1;
         all_rel_q <= 1'b0;
         llc_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         filt_q    <= filt_d;
         hold_q    <= hold_d;
         gap_q     <= gap_d;
         rst_out_q <= rst_out_d;
         all_rel_q <= all_rel_d;
         llc_q     <= llc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_LOCK: if (locked && filt_q == FILT_TERM) state_d = HOLD;
         HOLD:      if (hold_q == HOLD_TERM) state_d = (STAGES == 1) ? RUN : RELEASE;
         RELEASE:   if (gap_q == GAP_TERM && rst_shift == '0) state_d = RUN;
         default:   ;
      endcase
      if (sw_hit)    state_d = HOLD;
      // Lock loss outranks a concurrent software request.
      if (lock_loss) state_d = WAIT_LOCK;
   end

   always_comb begin
      filt_d    = filt_q;
      hold_d    = hold_q;
      gap_d     = gap_q;
      rst_out_d = rst_out_q;
      all_rel_d = all_rel_q;
      llc_d     = llc_q;
      case (state_q)
         WAIT_LOCK: begin
            hold_d = '0;
            if (!locked || filt_q == FILT_TERM) filt_d = '0;
            else                                filt_d = filt_q + FW'(1);
         end
         HOLD: begin
            if (hold_q == HOLD_TERM) begin
               hold_d    = '0;
               gap_d     = '0;
               rst_out_d = rst_shift;
               all_rel_d = (STAGES == 1);
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         RELEASE: begin
            if (gap_q == GAP_TERM) begin
               gap_d     = '0;
               rst_out_d = rst_shift;
               all_rel_d = (rst_shift == '0);
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: ;
      endcase
      if (sw_hit) begin
         rst_out_d = '1;
         all_rel_d = 1'b0;
         hold_d    = '0;
      end
      if (lock_loss) begin
         rst_out_d = '1;
         all_rel_d = 1'b0;
         filt_d    = '0;
         if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
      end
   end

   assign rst_out       = rst_out_q;
   assign all_released  = all_rel_q;
   assign state         = state_q;
   assign lock_loss_cnt = llc_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_FILTER, default 4: consecutive cycles `locked` must be sampled high before the hold phase starts; legal range >=1.
REQ-002 SHALL have parameter HOLD_CYCLES, default 128: length of the hold phase in cycles; legal range >=1.
REQ-003 SHALL have parameter STAGES, default 2: number of reset domains released in sequence; legal range 1..8.
REQ-004 SHALL have parameter STAGE_GAP, default 16: cycles between consecutive stage releases; legal range >=1.
REQ-005 SHALL have one clock and a synchronous, active-high reset, named as follows:
  c  input  1  sole clock; all state changes on rising edge.
  r  input  1  reset; synchronous, active-high.
REQ-006 SHALL have the remaining ports:
  locked  input  1  PLL lock indication, synchronous to c (tie 1 when no PLL is used).
  sw_rst_req  input  1  software reset request, level-sampled each cycle.
  rst_out  output  STAGES  per-domain resets, active-high; bit 0 is released first.
  all_released  output  1  high only in RUN.
  state  output  2  FSM state: 0=WAIT_LOCK, 1=HOLD, 2=RELEASE, 3=RUN.
  lock_loss_cnt  output  8  saturating count of lock-loss events.
REQ-007 SHALL register every output; no combinational path from any input to any output.

Function
REQ-008 WAIT_LOCK SHALL keep a filter counter.
  - Increments each cycle `locked`=1.
  - Clears to 0 on any cycle `locked`=0.
  - When `locked`=1 and filter==LOCK_FILTER-1, next state is HOLD.
REQ-009 HOLD SHALL hold for exactly HOLD_CYCLES cycles.
  - Hold counter starts at 0 on entry.
  - When counter==HOLD_CYCLES-1, next state is RELEASE; if STAGES==1, next state is RUN.
REQ-010 On the edge entering RELEASE (or RUN when STAGES==1), rst_out[0] SHALL go low.
REQ-011 rst_out[k] SHALL go low exactly k*STAGE_GAP cycles after rst_out[0] went low, for k=1..STAGES-1.
REQ-012 The edge on which rst_out[STAGES-1] goes low SHALL also enter RUN and set all_released=1.
REQ-013 Once released, an rst_out bit SHALL stay low until the next re-assertion event (REQ-014 to REQ-016).
REQ-014 Lock loss: `locked`=0 in HOLD, RELEASE or RUN SHALL, on the next edge:
  - set state to WAIT_LOCK;
  - set all rst_out bits to 1 and all_released to 0;
  - clear the filter counter;
  - increment lock_loss_cnt, saturating at 255.
REQ-015 sw_rst_req=1 in RELEASE or RUN SHALL, on the next edge:
  - set state to HOLD;
  - set all rst_out bits to 1 and all_released to 0;
  - restart the hold counter at 0.
  - lock_loss_cnt is unchanged.
REQ-016 sw_rst_req=1 in HOLD SHALL restart the hold counter at 0; sw_rst_req SHALL be ignored in WAIT_LOCK.
REQ-017 Simultaneous lock loss and sw_rst_req SHALL be handled as lock loss only (REQ-014).
REQ-018 A held-high sw_rst_req SHALL keep the block in HOLD with the counter at 0 until it drops.
REQ-019 Counter widths SHALL be $clog2 of their terminal value plus 1, so that no wrap occurs below the terminal value.

Reset
REQ-020 r=1 SHALL force, on the next edge:
  - state=WAIT_LOCK;
  - rst_out all 1s, all_released=0;
  - all internal counters 0, lock_loss_cnt=0.
  This applies regardless of current state, including mid-RELEASE.
REQ-021 While r=1, rst_out SHALL remain all 1s and no counter SHALL advance.
REQ-022 Power-up register initial values SHALL equal the reset values.

Verification
REQ-023 Nominal start, defaults, `locked`=1 constant, r deasserted before cycle 0:
  -> state=HOLD at cycle 4;
  -> rst_out=2'b10 and state=RELEASE at cycle 132;
  -> rst_out=2'b00, all_released=1, state=RUN at cycle 148.
REQ-024 Lock glitch during filtering: `locked`=1,1,1,0,1,... from cycle 0
  -> filter restarts; HOLD entered at cycle 8.
REQ-025 Lock drop in RUN for 1 cycle:
  -> next edge: rst_out=2'b11, state=WAIT_LOCK, lock_loss_cnt=1;
  -> full sequence repeats.
  256 such drops -> lock_loss_cnt=255.
REQ-026 sw_rst_req pulse in RELEASE at cycle 140:
  -> rst_out=2'b11, state=HOLD at cycle 141;
  -> rst_out[0] low at cycle 269; RUN at cycle 285.
REQ-027 r asserted at cycle 140, mid-RELEASE:
  -> cycle 141: rst_out=2'b11, state=0, lock_loss_cnt=0.
REQ-028 STAGES=1, HOLD_CYCLES=1, LOCK_FILTER=1, STAGE_GAP=1, `locked`=1 constant:
  -> HOLD at cycle 1; RUN with rst_out=1'b0 at cycle 2.
